// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 capture path.
package ov7670_pkg;

    localparam int H_ACTIVE_DEFAULT = 640;
    localparam int V_ACTIVE_DEFAULT = 480;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        VBLANK = 2'd1,
        ACTIVE = 2'd2
    } cap_state_e;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    function automatic rgb565_t rgb565_fields(input logic [15:0] p);
        rgb565_fields.r = p[15:11];
        rgb565_fields.g = p[10:5];
        rgb565_fields.b = p[4:0];
    endfunction

endpackage

// File: rtl/ov7670_byte_pair.sv
// Input register stage, sync edge detection and byte-pair assembly for the camera stream.
module ov7670_byte_pair
    import ov7670_pkg::*;
#(
    parameter int FIRST_BYTE_HIGH   = 1,
    parameter int VSYNC_ACTIVE_HIGH = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        vsync_i,
    input  logic        href_i,
    input  logic [7:0]  data_i,
    input  logic        phase_clr_i,
    output logic        vs_rise_o,
    output logic        vs_fall_o,
    output logic        pix_valid_o,
    output logic [15:0] pix_data_o,
    output logic        line_end_o,
    output logic        line_odd_o
);
    logic        vs_q, vs_prev_q;
    logic        hr_q, hr_prev_q;
    logic [7:0]  data_q;
    logic        phase_q;
    logic [7:0]  first_q;
    logic        pix_valid_q;
    logic [15:0] pix_data_q;
    logic        line_end_q;
    logic        line_odd_q;

    // line_end is delayed one cycle so the parent's X count already includes the last pixel.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vs_q        <= 1'b0;
            vs_prev_q   <= 1'b0;
            hr_q        <= 1'b0;
            hr_prev_q   <= 1'b0;
            data_q      <= 8'd0;
            phase_q     <= 1'b0;
            first_q     <= 8'd0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= 16'd0;
            line_end_q  <= 1'b0;
            line_odd_q  <= 1'b0;
        end else begin
            vs_q        <= (VSYNC_ACTIVE_HIGH != 0) ? vsync_i : ~vsync_i;
            vs_prev_q   <= vs_q;
            hr_q        <= href_i;
            hr_prev_q   <= hr_q;
            data_q      <= data_i;
            pix_valid_q <= 1'b0;
            line_end_q  <= hr_prev_q & ~hr_q;
            line_odd_q  <= phase_q;
            if (!hr_q || phase_clr_i) begin
                phase_q <= 1'b0;
            end else if (!phase_q) begin
                first_q <= data_q;
                phase_q <= 1'b1;
            end else begin
                pix_valid_q <= 1'b1;
                pix_data_q  <= (FIRST_BYTE_HIGH != 0) ? {first_q, data_q} : {data_q, first_q};
                phase_q     <= 1'b0;
            end
        end
    end

    assign vs_rise_o   = vs_q & ~vs_prev_q;
    assign vs_fall_o   = ~vs_q & vs_prev_q;
    assign pix_valid_o = pix_valid_q;
    assign pix_data_o  = pix_data_q;
    assign line_end_o  = line_end_q;
    assign line_odd_o  = line_odd_q;

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 RGB565 capture: frame lock on VSYNC, X/Y tracking and frame-buffer write strobes.
module ov7670_capture
    import ov7670_pkg::*;
#(
    parameter int H_ACTIVE          = H_ACTIVE_DEFAULT,
    parameter int V_ACTIVE          = V_ACTIVE_DEFAULT,
    parameter int FIRST_BYTE_HIGH   = 1,
    parameter int VSYNC_ACTIVE_HIGH = 1
) (
    input  logic        writeClk,
    input  logic        resetN,
    input  logic        vsync,
    input  logic        href,
    input  logic [7:0]  camData,
    output logic [9:0]  outX,
    output logic [8:0]  outY,
    output logic        writeEn,
    output logic [15:0] pixelOut,
    output logic        frameDone,
    output logic        lineErr,
    output logic [7:0]  frameCount
);
    localparam logic [9:0] X_LIMIT = 10'(H_ACTIVE);
    localparam logic [8:0] Y_LIMIT = 9'(V_ACTIVE);
    localparam logic [9:0] X_MAX   = '1;
    localparam logic [8:0] Y_MAX   = '1;

    logic        vs_rise, vs_fall, pix_valid, line_end, line_odd, phase_clr;
    logic [15:0] pix_data;

    cap_state_e  state_q, state_d;
    logic [9:0]  x_q, x_d, out_x_q, out_x_d;
    logic [8:0]  y_q, y_d, out_y_q, out_y_d;
    logic        we_q, we_d, done_q, done_d, err_q, err_d;
    rgb565_t     pixel_q, pixel_d;
    logic [7:0]  count_q, count_d;

    ov7670_byte_pair #(
        .FIRST_BYTE_HIGH  (FIRST_BYTE_HIGH),
        .VSYNC_ACTIVE_HIGH(VSYNC_ACTIVE_HIGH)
    ) u_byte_pair (
        .clk_i      (writeClk),
        .rst_ni     (resetN),
        .vsync_i    (vsync),
        .href_i     (href),
        .data_i     (camData),
        .phase_clr_i(phase_clr),
        .vs_rise_o  (vs_rise),
        .vs_fall_o  (vs_fall),
        .pix_valid_o(pix_valid),
        .pix_data_o (pix_data),
        .line_end_o (line_end),
        .line_odd_o (line_odd)
    );

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        we_d      = 1'b0;
        out_x_d   = out_x_q;
        out_y_d   = out_y_q;
        pixel_d   = pixel_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        count_d   = count_q;
        phase_clr = 1'b0;
        case (state_q)
            SYNC: begin
                if (vs_rise) state_d = VBLANK;
            end
            VBLANK: begin
                if (vs_fall) begin
                    state_d   = ACTIVE;
                    x_d       = 10'd0;
                    y_d       = 9'd0;
                    phase_clr = 1'b1;
                end
            end
            ACTIVE: begin
                if (pix_valid) begin
                    if (x_q < X_LIMIT && y_q < Y_LIMIT) begin
                        we_d    = 1'b1;
                        out_x_d = x_q;
                        out_y_d = y_q;
                        pixel_d = rgb565_fields(pix_data);
                    end
                    if (x_q != X_MAX) x_d = x_q + 10'd1;
                end
                // A vsync rise abandons any line still in flight, so line_end is ignored here.
                if (vs_rise) begin
                    done_d  = 1'b1;
                    count_d = count_q + 8'd1;
                    state_d = VBLANK;
                end else if (line_end) begin
                    if (line_odd || (x_q != 10'd0 && x_q != X_LIMIT)) err_d = 1'b1;
                    if (x_q != 10'd0 && y_q != Y_MAX) y_d = y_q + 9'd1;
                    x_d = 10'd0;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge writeClk or negedge resetN) begin
        if (!resetN) begin
            state_q <= SYNC;
            x_q     <= 10'd0;
            y_q     <= 9'd0;
            we_q    <= 1'b0;
            out_x_q <= 10'd0;
            out_y_q <= 9'd0;
            pixel_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            we_q    <= we_d;
            out_x_q <= out_x_d;
            out_y_q <= out_y_d;
            pixel_q <= pixel_d;
            done_q  <= done_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    assign outX       = out_x_q;
    assign outY       = out_y_q;
    assign writeEn    = we_q;
    assign pixelOut   = pixel_q;
    assign frameDone  = done_q;
    assign lineErr    = err_q;
    assign frameCount = count_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// Bench for ov7670_capture: byte-stream driver, frame-level reference model and write scoreboard.
module tb_ov7670_capture;
  localparam int H = 16;
  localparam int V = 6;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic vsync = 1'b0;
  logic href = 1'b0;
  logic [7:0] camData = 8'd0;
  logic vsync_n;
  assign vsync_n = ~vsync;

  logic [9:0] a_outX, b_outX;
  logic [8:0] a_outY, b_outY;
  logic a_writeEn, b_writeEn, a_frameDone, b_frameDone, a_lineErr, b_lineErr;
  logic [15:0] a_pixelOut, b_pixelOut;
  logic [7:0] a_frameCount, b_frameCount;

  always #5 clk = ~clk;

  // Instance a: high byte first, active-high vsync. Instance b: low byte first, inverted vsync.
  ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .FIRST_BYTE_HIGH(1), .VSYNC_ACTIVE_HIGH(1)) dut_a (
    .writeClk(clk), .resetN(resetN), .vsync(vsync), .href(href), .camData(camData),
    .outX(a_outX), .outY(a_outY), .writeEn(a_writeEn), .pixelOut(a_pixelOut),
    .frameDone(a_frameDone), .lineErr(a_lineErr), .frameCount(a_frameCount));

  ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .FIRST_BYTE_HIGH(0), .VSYNC_ACTIVE_HIGH(0)) dut_b (
    .writeClk(clk), .resetN(resetN), .vsync(vsync_n), .href(href), .camData(camData),
    .outX(b_outX), .outY(b_outY), .writeEn(b_writeEn), .pixelOut(b_pixelOut),
    .frameDone(b_frameDone), .lineErr(b_lineErr), .frameCount(b_frameCount));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: 0 = waiting for vsync rise, 1 = waiting for fall, 2 = capturing.
  logic [34:0] exp_q[$];
  int m_state = 0;
  int m_x = 0, m_y = 0, m_bytes = 0, m_frames = 0;
  int exp_err = 0, exp_done = 0;
  logic [7:0] m_first = 8'd0;

  int wr_cnt = 0, err_cnt = 0, done_cnt = 0;
  logic [9:0] last_x = 0, first_x = 0;
  logic [8:0] last_y = 0, first_y = 0;
  logic [15:0] last_pix = 0;
  bit got_first = 0;
  logic prev_we = 1'b0;

  always @(negedge clk) begin
    if (resetN) begin
      if (a_writeEn) begin
        logic [34:0] e;
        wr_cnt++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write got x=%0d y=%0d pix=%h, expected no write", a_outX, a_outY, a_pixelOut);
        end else begin
          e = exp_q.pop_front();
          if ({a_outX, a_outY, a_pixelOut} !== e) begin
            n_err++;
            $display("FAIL write_a got x=%0d y=%0d pix=%h expected x=%0d y=%0d pix=%h",
                     a_outX, a_outY, a_pixelOut, e[34:25], e[24:16], e[15:0]);
          end
          n_cmp++;
          if ({b_outX, b_outY, b_pixelOut} !== {e[34:16], e[7:0], e[15:8]}) begin
            n_err++;
            $display("FAIL write_b got x=%0d y=%0d pix=%h expected x=%0d y=%0d pix=%h",
                     b_outX, b_outY, b_pixelOut, e[34:25], e[24:16], {e[7:0], e[15:8]});
          end
        end
        n_cmp++;
        if (a_outX >= H || a_outY >= V) begin
          n_err++;
          $display("FAIL write_range got x=%0d y=%0d expected x<%0d y<%0d", a_outX, a_outY, H, V);
        end
        last_x = a_outX; last_y = a_outY; last_pix = a_pixelOut;
        if (!got_first) begin
          first_x = a_outX; first_y = a_outY; got_first = 1;
        end
      end
      n_cmp++;
      if (a_writeEn && prev_we) begin
        n_err++;
        $display("FAIL we_consecutive got 1,1 expected at most one strobe per two cycles");
      end
      n_cmp++;
      if ({b_writeEn, b_lineErr, b_frameDone, b_frameCount} !== {a_writeEn, a_lineErr, a_frameDone, a_frameCount}) begin
        n_err++;
        $display("FAIL b_tracks_a got we=%b err=%b done=%b cnt=%0d expected we=%b err=%b done=%b cnt=%0d",
                 b_writeEn, b_lineErr, b_frameDone, b_frameCount, a_writeEn, a_lineErr, a_frameDone, a_frameCount);
      end
      n_cmp++;
      if (a_lineErr && a_frameDone) begin
        n_err++;
        $display("FAIL err_done_overlap got both=1 expected never together");
      end
      if (a_lineErr) err_cnt++;
      if (a_frameDone) done_cnt++;
      prev_we = a_writeEn;
    end else begin
      prev_we = 1'b0;
    end
  end

  task automatic model_byte(input logic [7:0] d);
    if (m_state == 2) begin
      m_bytes++;
      if (m_bytes % 2 == 1) m_first = d;
      else begin
        if (m_x < H && m_y < V) exp_q.push_back({10'(m_x), 9'(m_y), m_first, d});
        if (m_x < 1023) m_x++;
      end
    end
  endtask

  task automatic model_line_end();
    if (m_state == 2 && m_bytes > 0) begin
      if ((m_bytes % 2 == 1) || (m_x != 0 && m_x != H)) exp_err++;
      if (m_x > 0 && m_y < 511) m_y++;
      m_x = 0;
    end
    m_bytes = 0;
  endtask

  task automatic put(input logic h, input logic [7:0] d);
    href = h;
    camData = d;
    if (h) model_byte(d);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) put(1'b0, 8'($urandom));
  endtask

  task automatic vsync_edge(input logic v);
    vsync = v;
    if (v) begin
      if (m_state == 2) begin
        exp_done++;
        m_frames++;
      end
      m_state = 1;
    end else if (m_state == 1) begin
      m_state = 2;
      m_x = 0; m_y = 0; m_bytes = 0;
    end
  endtask

  task automatic vsync_pulse();
    vsync_edge(1'b1); idle(4);
    vsync_edge(1'b0); idle(4);
  endtask

  task automatic send_line(input int nbytes, input bit ramp);
    logic [15:0] val;
    val = 16'd0;
    for (int i = 0; i < nbytes; i++) begin
      if (i % 2 == 0) val = ramp ? 16'(i / 2) : 16'($urandom);
      put(1'b1, (i % 2 == 0) ? val[15:8] : val[7:0]);
    end
    model_line_end();
    idle(4);
  endtask

  task automatic do_reset(input logic keep_href);
    resetN = 1'b0;
    exp_q.delete();
    m_state = 0; m_x = 0; m_y = 0; m_bytes = 0; m_frames = 0;
    repeat (3) put(keep_href, 8'($urandom));
    n_cmp++;
    if ({a_outX, a_outY, a_writeEn, a_pixelOut, a_frameDone, a_lineErr, a_frameCount} !== '0 ||
        {b_outX, b_outY, b_writeEn, b_pixelOut, b_frameDone, b_lineErr, b_frameCount} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got a=%h b=%h expected 0",
               {a_outX, a_outY, a_writeEn, a_pixelOut, a_frameDone, a_lineErr, a_frameCount},
               {b_outX, b_outY, b_writeEn, b_pixelOut, b_frameDone, b_lineErr, b_frameCount});
    end
    resetN = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    idle(2);
  endtask

  task automatic test_full_frames();
    int w0, d0;
    d0 = done_cnt;
    vsync_pulse();
    w0 = wr_cnt;
    for (int l = 0; l < V; l++) send_line(2 * H, 1'b1);
    n_cmp++;
    if (wr_cnt - w0 !== H * V) begin
      n_err++; $display("FAIL frame1_writes got %0d expected %0d", wr_cnt - w0, H * V);
    end
    n_cmp++;
    if ({last_x, last_y, last_pix} !== {10'(H - 1), 9'(V - 1), 16'(H - 1)}) begin
      n_err++; $display("FAIL frame1_last got x=%0d y=%0d pix=%0d expected x=%0d y=%0d pix=%0d",
                        last_x, last_y, last_pix, H - 1, V - 1, H - 1);
    end
    vsync_pulse();
    w0 = wr_cnt;
    for (int l = 0; l < V; l++) send_line(2 * H, 1'b0);
    vsync_edge(1'b1); idle(4);
    n_cmp++;
    if (wr_cnt - w0 !== H * V) begin
      n_err++; $display("FAIL frame2_writes got %0d expected %0d", wr_cnt - w0, H * V);
    end
    n_cmp++;
    if (done_cnt - d0 !== 2) begin
      n_err++; $display("FAIL frame_done_pulses got %0d expected 2", done_cnt - d0);
    end
    n_cmp++;
    if (a_frameCount !== 8'd2) begin
      n_err++; $display("FAIL frame_count got %0d expected 2", a_frameCount);
    end
    vsync_edge(1'b0); idle(4);
  endtask

  task automatic test_byte_order();
    int e0;
    e0 = err_cnt;
    put(1'b1, 8'hF8);
    put(1'b1, 8'h1F);
    model_line_end();
    put(1'b0, 8'h00);
    n_cmp++;
    if (a_writeEn !== 1'b0) begin
      n_err++; $display("FAIL latency_edge1 got we=%b expected 0", a_writeEn);
    end
    put(1'b0, 8'h00);
    n_cmp++;
    if ({a_writeEn, a_pixelOut, b_pixelOut} !== {1'b1, 16'hF81F, 16'h1FF8}) begin
      n_err++; $display("FAIL latency_edge2 got we=%b a=%h b=%h expected we=1 a=f81f b=1ff8",
                        a_writeEn, a_pixelOut, b_pixelOut);
    end
    put(1'b0, 8'h00);
    n_cmp++;
    if (a_writeEn !== 1'b0) begin
      n_err++; $display("FAIL latency_edge3 got we=%b expected 0", a_writeEn);
    end
    idle(3);
    n_cmp++;
    if (err_cnt - e0 !== 1) begin
      n_err++; $display("FAIL short_line_err got %0d expected 1", err_cnt - e0);
    end
  endtask

  task automatic test_odd_line();
    int e0, w0;
    vsync_pulse();
    e0 = err_cnt; w0 = wr_cnt;
    send_line(2 * H - 1, 1'b0);
    n_cmp++;
    if (err_cnt - e0 !== 1) begin
      n_err++; $display("FAIL odd_line_err got %0d expected 1", err_cnt - e0);
    end
    n_cmp++;
    if (wr_cnt - w0 !== H - 1) begin
      n_err++; $display("FAIL odd_line_writes got %0d expected %0d", wr_cnt - w0, H - 1);
    end
    got_first = 0;
    send_line(2 * H, 1'b0);
    n_cmp++;
    if (!got_first || first_x !== 10'd0 || first_y !== 9'd1) begin
      n_err++; $display("FAIL odd_next_line got seen=%0d x=%0d y=%0d expected x=0 y=1", got_first, first_x, first_y);
    end
  endtask

  task automatic test_long_lines();
    int e0, w0;
    vsync_pulse();
    e0 = err_cnt; w0 = wr_cnt;
    send_line(2 * (H + 8), 1'b0);
    n_cmp++;
    if (err_cnt - e0 !== 1 || wr_cnt - w0 !== H) begin
      n_err++; $display("FAIL long_line got err=%0d writes=%0d expected err=1 writes=%0d", err_cnt - e0, wr_cnt - w0, H);
    end
    for (int l = 1; l < V + 2; l++) send_line(2 * H, 1'b0);
    n_cmp++;
    if (wr_cnt - w0 !== H * V) begin
      n_err++; $display("FAIL tall_frame_writes got %0d expected %0d", wr_cnt - w0, H * V);
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    vsync_pulse();
    for (int l = 0; l < 3; l++) send_line(2 * H, 1'b0);
    for (int i = 0; i < H; i++) put(1'b1, 8'($urandom));
    do_reset(1'b1);
    w0 = wr_cnt;
    for (int i = 0; i < H; i++) put(1'b1, 8'($urandom));
    model_line_end();
    idle(4);
    for (int l = 0; l < 2; l++) send_line(2 * H, 1'b0);
    n_cmp++;
    if (wr_cnt - w0 !== 0 || a_frameCount !== 8'd0) begin
      n_err++; $display("FAIL post_reset_quiet got writes=%0d cnt=%0d expected 0 0", wr_cnt - w0, a_frameCount);
    end
    vsync_pulse();
    got_first = 0;
    send_line(2 * H, 1'b0);
    n_cmp++;
    if (!got_first || first_x !== 10'd0 || first_y !== 9'd0) begin
      n_err++; $display("FAIL post_reset_first got seen=%0d x=%0d y=%0d expected x=0 y=0", got_first, first_x, first_y);
    end
  endtask

  task automatic test_vsync_abandon();
    int e0, d0;
    e0 = err_cnt; d0 = done_cnt;
    for (int i = 0; i < H; i++) put(1'b1, 8'($urandom));
    vsync_edge(1'b1);
    for (int i = 0; i < 4; i++) put(1'b1, 8'($urandom));
    model_line_end();
    idle(4);
    n_cmp++;
    if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
      n_err++; $display("FAIL abandon_pulses got done=%0d err=%0d expected done=1 err=0", done_cnt - d0, err_cnt - e0);
    end
    n_cmp++;
    if (last_x !== 10'(H / 2 - 1)) begin
      n_err++; $display("FAIL abandon_last_x got %0d expected %0d", last_x, H / 2 - 1);
    end
    vsync_edge(1'b0); idle(4);
    got_first = 0;
    send_line(2 * H, 1'b0);
    n_cmp++;
    if (!got_first || first_x !== 10'd0 || first_y !== 9'd0) begin
      n_err++; $display("FAIL abandon_next_first got seen=%0d x=%0d y=%0d expected x=0 y=0", got_first, first_x, first_y);
    end
  endtask

  task automatic test_totals();
    vsync_edge(1'b1); idle(4);
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++; $display("FAIL pending_writes got %0d left expected 0", exp_q.size());
    end
    n_cmp++;
    if (err_cnt !== exp_err || done_cnt !== exp_done) begin
      n_err++; $display("FAIL pulse_totals got err=%0d done=%0d expected err=%0d done=%0d", err_cnt, done_cnt, exp_err, exp_done);
    end
    n_cmp++;
    if (a_frameCount !== 8'(m_frames)) begin
      n_err++; $display("FAIL final_frame_count got %0d expected %0d", a_frameCount, m_frames);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_full_frames();
    test_byte_order();
    test_odd_line();
    test_long_lines();
    test_reset_mid();
    test_vsync_abandon();
    test_totals();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
